// File: rtl/snvs_lp_zmk_pkg.sv
// Shared types and defaults for the SNVS LP zeroizable master-key bank.
// Optional parity support is enabled with SNVS_ZMK_PARITY_EN.
package snvs_lp_zmk_pkg;

  localparam int DEF_KEY_WIDTH  = 256;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int MAX_PAR_WIDTH  = 256;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WIPE1  = 3'd1,
    ST_WIPE0  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } zmk_state_t;

  // Even parity bit: makes the total count of ones (data plus bit) even.
  function automatic logic even_parity(input logic [MAX_PAR_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/snvs_lp_zmk_word.sv
// One key word: write / wipe-ones / wipe-zeros register with synchronous reset.
// With SNVS_ZMK_PARITY_EN an even-parity bit is stored and checked locally.
module snvs_lp_zmk_word
  import snvs_lp_zmk_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  wr_i,
  input  logic                  wipe1_i,
  input  logic                  wipe0_i,
  input  logic                  chk_en_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  par_err_o
);

  logic [WORD_WIDTH-1:0] word_q, word_d;

  // Wipes take priority; the bank never issues a write while wiping.
  always_comb begin
    word_d = word_q;
    if (wipe1_i) begin
      word_d = '1;
    end else if (wipe0_i) begin
      word_d = '0;
    end else if (wr_i) begin
      word_d = data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign data_o = word_q;

`ifdef SNVS_ZMK_PARITY_EN
  logic par_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      par_q <= 1'b0;
    end else if (wipe1_i || wipe0_i || wr_i) begin
      par_q <= even_parity(MAX_PAR_WIDTH'(word_d));
    end
  end

  assign par_err_o = chk_en_i & (par_q != even_parity(MAX_PAR_WIDTH'(word_q)));
`else
  logic unused_chk_en;
  assign unused_chk_en = chk_en_i;
  assign par_err_o     = 1'b0;
`endif

endmodule

// File: rtl/snvs_lp_zmk_bank.sv
// Zeroizable master-key bank: word writes, sticky lock, multi-pass wipe with verify,
// and key output gated on all words written. Parity option: SNVS_ZMK_PARITY_EN.
module snvs_lp_zmk_bank
  import snvs_lp_zmk_pkg::*;
#(
  parameter  int KEY_WIDTH  = DEF_KEY_WIDTH,
  parameter  int WORD_WIDTH = DEF_WORD_WIDTH,
  localparam int NUM_WORDS  = KEY_WIDTH / WORD_WIDTH,
  localparam int AW         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  input  logic                  lock_set_i,
  input  logic                  zeroize_req_i,
  output logic [KEY_WIDTH-1:0]  key_out_o,
  output logic                  key_valid_o,
  output logic                  locked_o,
  output logic                  wr_error_o,
  output logic                  zeroize_busy_o,
  output logic                  zeroize_done_o,
  output logic                  zeroize_fail_o,
  output logic                  par_error_o
);

  zmk_state_t           state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [NUM_WORDS-1:0] mask_q, mask_d;
  logic                 locked_q, wr_error_q, fail_q, par_error_q;

  logic [WORD_WIDTH-1:0] word_data [NUM_WORDS];
  logic [NUM_WORDS-1:0]  word_par_err, word_wr, word_wipe1, word_wipe0;
  logic [KEY_WIDTH-1:0]  key_flat;
  logic                  is_idle, par_hit, zstart, addr_ok, wr_accept, last_word;

  assign is_idle   = (state_q == ST_IDLE);
  assign par_hit   = |word_par_err;
  // A parity hit starts the same wipe sequence as an explicit request.
  assign zstart    = is_idle & (zeroize_req_i | par_hit);
  assign addr_ok   = (int'(wr_addr_i) < NUM_WORDS);
  assign wr_accept = wr_en_i & is_idle & ~locked_q & addr_ok & ~zstart;
  assign last_word = (cnt_q == AW'(NUM_WORDS - 1));

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : gen_word
    assign word_wr[gi]    = wr_accept & (wr_addr_i == AW'(gi));
    assign word_wipe1[gi] = (state_q == ST_WIPE1) & (cnt_q == AW'(gi));
    assign word_wipe0[gi] = (state_q == ST_WIPE0) & (cnt_q == AW'(gi));

    snvs_lp_zmk_word #(.WORD_WIDTH(WORD_WIDTH)) u_word (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .wr_i     (word_wr[gi]),
      .wipe1_i  (word_wipe1[gi]),
      .wipe0_i  (word_wipe0[gi]),
      .chk_en_i (mask_q[gi]),
      .data_i   (wr_data_i),
      .data_o   (word_data[gi]),
      .par_err_o(word_par_err[gi])
    );

    assign key_flat[gi*WORD_WIDTH +: WORD_WIDTH] = word_data[gi];
  end

  always_comb begin
    mask_d = mask_q | word_wr;
    if (zstart) begin
      mask_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (zstart) begin
          state_d = ST_WIPE1;
          cnt_d   = '0;
        end
      end
      ST_WIPE1: begin
        if (last_word) begin
          state_d = ST_WIPE0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_WIPE0: begin
        if (last_word) begin
          state_d = ST_VERIFY;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_VERIFY: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      locked_q    <= 1'b0;
      wr_error_q  <= 1'b0;
      fail_q      <= 1'b0;
      par_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      locked_q    <= locked_q | lock_set_i;
      wr_error_q  <= wr_en_i & ~wr_accept;
      par_error_q <= par_error_q | par_hit;
      // Verify looks at raw storage, not the gated key output.
      if ((state_q == ST_VERIFY) && (|key_flat)) begin
        fail_q <= 1'b1;
      end
    end
  end

  assign key_valid_o    = &mask_q;
  assign key_out_o      = key_valid_o ? key_flat : '0;
  assign locked_o       = locked_q;
  assign wr_error_o     = wr_error_q;
  assign zeroize_busy_o = (state_q == ST_WIPE1) || (state_q == ST_WIPE0) || (state_q == ST_VERIFY);
  assign zeroize_done_o = (state_q == ST_DONE);
  assign zeroize_fail_o = fail_q;
  assign par_error_o    = par_error_q;

endmodule

// File: tb/tb_snvs_lp_zmk_bank.sv
// Bench for snvs_lp_zmk_bank: vector table plus hand-built zeroize/reset sequences.
// Build with SNVS_ZMK_PARITY_EN to exercise the parity-triggered zeroize.
module tb_snvs_lp_zmk_bank;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          wr_en_i = 1'b0;
  logic [2:0]    wr_addr_i = '0;
  logic [31:0]   wr_data_i = '0;
  logic          lock_set_i = 1'b0;
  logic          zeroize_req_i = 1'b0;
  logic [255:0]  key_out_o;
  logic          key_valid_o, locked_o, wr_error_o;
  logic          zeroize_busy_o, zeroize_done_o, zeroize_fail_o, par_error_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid, locked, wr_err, busy, done, fail, par;
    int          kw_idx;
    logic [31:0] kw_val;
  } exp_t;

  typedef struct {
    logic        rst, we;
    logic [2:0]  a;
    logic [31:0] d;
    logic        lk, zr;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  snvs_lp_zmk_bank dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .lock_set_i    (lock_set_i),
    .zeroize_req_i (zeroize_req_i),
    .key_out_o     (key_out_o),
    .key_valid_o   (key_valid_o),
    .locked_o      (locked_o),
    .wr_error_o    (wr_error_o),
    .zeroize_busy_o(zeroize_busy_o),
    .zeroize_done_o(zeroize_done_o),
    .zeroize_fail_o(zeroize_fail_o),
    .par_error_o   (par_error_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic exp_t mk_exp(input logic v, input logic l, input logic we, input logic b,
                                  input logic dn, input logic f, input logic p,
                                  input int idx, input logic [31:0] val);
    exp_t e;
    e.valid = v; e.locked = l; e.wr_err = we; e.busy = b; e.done = dn;
    e.fail = f; e.par = p; e.kw_idx = idx; e.kw_val = val;
    return e;
  endfunction

  function automatic vec_t mkv(input logic rst, input logic we, input logic [2:0] a,
                               input logic [31:0] d, input logic lk, input logic zr, input exp_t e);
    vec_t v;
    v.rst = rst; v.we = we; v.a = a; v.d = d; v.lk = lk; v.zr = zr; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    chk({tag, "/key_valid"}, 32'(key_valid_o), 32'(e.valid));
    chk({tag, "/locked"}, 32'(locked_o), 32'(e.locked));
    chk({tag, "/wr_error"}, 32'(wr_error_o), 32'(e.wr_err));
    chk({tag, "/busy"}, 32'(zeroize_busy_o), 32'(e.busy));
    chk({tag, "/done"}, 32'(zeroize_done_o), 32'(e.done));
    chk({tag, "/fail"}, 32'(zeroize_fail_o), 32'(e.fail));
    chk({tag, "/par_error"}, 32'(par_error_o), 32'(e.par));
    if (e.kw_idx >= 0) begin
      chk($sformatf("%s/key_word%0d", tag, e.kw_idx), key_out_o[e.kw_idx*32 +: 32], e.kw_val);
    end else if (!e.valid) begin
      checks++;
      if (key_out_o !== '0) begin
        errors++;
        $display("FAIL %s/key_out_zero: got nonzero %h expected 0", tag, key_out_o);
      end
    end
  endtask

  // Drive one cycle's inputs, queue the expectation, compare one cycle later.
  task automatic drive(input vec_t v, input string tag);
    exp_t e;
    reset_i = v.rst; wr_en_i = v.we; wr_addr_i = v.a; wr_data_i = v.d;
    lock_set_i = v.lk; zeroize_req_i = v.zr;
    sb_q.push_back(v.e);
    @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0; wr_en_i = 1'b0; lock_set_i = 1'b0; zeroize_req_i = 1'b0;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s/scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      compare_outputs(tag, e);
      $display("txn %s rst=%0b we=%0b a=%0d d=%h lk=%0b zr=%0b -> valid=%0b busy=%0b done=%0b werr=%0b",
               tag, v.rst, v.we, v.a, v.d, v.lk, v.zr, key_valid_o, zeroize_busy_o,
               zeroize_done_o, wr_error_o);
    end
  endtask

  task automatic idle_cycle(input string tag, input exp_t e);
    drive(mkv(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, e), tag);
  endtask

  initial begin
    logic par_exp;
    par_exp = 1'b0;

    repeat (3) @(negedge clock_i);
    compare_outputs("reset", mk_exp(0, 0, 0, 0, 0, 0, 0, -1, 32'd0));

    // Table: program all words, then lock-with-write and a rejected locked write.
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mkv(1'b0, 1'b1, 3'(i), 32'(32'h11111111 * (i + 1)), 1'b0, 1'b0,
                         mk_exp(i == 7, 0, 0, 0, 0, 0, 0, (i == 7) ? 0 : -1, 32'h11111111)));
    end
    vecs.push_back(mkv(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, mk_exp(1, 0, 0, 0, 0, 0, 0, 7, 32'h88888888)));
    vecs.push_back(mkv(1'b0, 1'b1, 3'd0, 32'hAAAA0000, 1'b1, 1'b0, mk_exp(1, 1, 0, 0, 0, 0, 0, 0, 32'hAAAA0000)));
    vecs.push_back(mkv(1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 1'b0, mk_exp(1, 1, 1, 0, 0, 0, 0, 3, 32'h44444444)));
    vecs.push_back(mkv(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, mk_exp(1, 1, 0, 0, 0, 0, 0, 3, 32'h44444444)));
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], $sformatf("vec%0d", i));
    end

    // Zeroize while locked: busy for 17 cycles, done on the 18th, lock retained.
    drive(mkv(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, mk_exp(0, 1, 0, 1, 0, 0, 0, -1, 32'd0)), "zlk1");
    for (int k = 2; k <= 19; k++) begin
      idle_cycle($sformatf("zlk%0d", k), mk_exp(0, 1, 0, k <= 17, k == 18, 0, 0, -1, 32'd0));
    end

    // Reset clears the lock; reprogram, then reset in the middle of WIPE1.
    drive(mkv(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, mk_exp(0, 0, 0, 0, 0, 0, 0, -1, 32'd0)), "rst1");
    for (int i = 0; i < 8; i++) begin
      drive(mkv(1'b0, 1'b1, 3'(i), 32'(32'h100 + i), 1'b0, 1'b0,
                mk_exp(i == 7, 0, 0, 0, 0, 0, 0, (i == 7) ? 7 : -1, 32'h107)), $sformatf("wr2_%0d", i));
    end
    drive(mkv(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, mk_exp(0, 0, 0, 1, 0, 0, 0, -1, 32'd0)), "zmid1");
    for (int k = 2; k <= 5; k++) begin
      idle_cycle($sformatf("zmid%0d", k), mk_exp(0, 0, 0, 1, 0, 0, 0, -1, 32'd0));
    end
    chk("zmid/cnt", 32'(dut.cnt_q), 32'd4);
    drive(mkv(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, mk_exp(0, 0, 0, 0, 0, 0, 0, -1, 32'd0)), "rst2");
    drive(mkv(1'b0, 1'b1, 3'd5, 32'h5A5A5A5A, 1'b0, 1'b0, mk_exp(0, 0, 0, 0, 0, 0, 0, -1, 32'd0)), "wr3_5");
    for (int i = 0; i < 8; i++) begin
      if (i != 5) begin
        drive(mkv(1'b0, 1'b1, 3'(i), 32'(32'h11111111 * (i + 1)), 1'b0, 1'b0,
                  mk_exp(i == 7, 0, 0, 0, 0, 0, 0, (i == 7) ? 5 : -1, 32'h5A5A5A5A)), $sformatf("wr3_%0d", i));
      end
    end

    // Simultaneous write+zeroize, then request and write during busy.
    drive(mkv(1'b0, 1'b1, 3'd1, 32'hFFFF0000, 1'b0, 1'b1, mk_exp(0, 0, 1, 1, 0, 0, 0, -1, 32'd0)), "zsim1");
    for (int k = 2; k <= 19; k++) begin
      drive(mkv(1'b0, k == 5, 3'd2, 32'h12345678, 1'b0, k == 5,
                mk_exp(0, 0, k == 5, k <= 17, k == 18, 0, 0, -1, 32'd0)), $sformatf("zsim%0d", k));
    end
    drive(mkv(1'b0, 1'b1, 3'd0, 32'hCAFEF00D, 1'b0, 1'b0, mk_exp(0, 0, 0, 0, 0, 0, 0, -1, 32'd0)), "post_wr");

`ifdef SNVS_ZMK_PARITY_EN
    for (int i = 1; i < 8; i++) begin
      drive(mkv(1'b0, 1'b1, 3'(i), 32'(32'h11111111 * (i + 1)), 1'b0, 1'b0,
                mk_exp(i == 7, 0, 0, 0, 0, 0, 0, (i == 7) ? 2 : -1, 32'h33333333)), $sformatf("wrp_%0d", i));
    end
    force dut.gen_word[2].u_word.word_q = 32'h33333332;
    #1;
    release dut.gen_word[2].u_word.word_q;
    par_exp = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      idle_cycle($sformatf("par%0d", k), mk_exp(0, 0, 0, k <= 17, k == 18, 0, par_exp, -1, 32'd0));
    end
`else
    idle_cycle("nopar", mk_exp(0, 0, 0, 0, 0, 0, par_exp, -1, 32'd0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snvs_lp_zmk_bank.md
# snvs_lp_zmk_bank

Parametrised zeroizable master-key (ZMK) register bank for the SNVS low-power domain. It replaces per-bit key flip-flops with a word-addressable key store that supports:
- a write-lock,
- a sequenced multi-pass hardware zeroization with completion and failure status,
- gated key output that is driven only once every word has been programmed.

It sits between the LP register interface (word writes) and the key consumer (full-width key_out).

## Interface
Parameters:
- KEY_WIDTH, 256, total key bits; must be an integer multiple of WORD_WIDTH
- WORD_WIDTH, 32, bits per programmable word
- NUM_WORDS (derived), KEY_WIDTH/WORD_WIDTH
- AW (derived), max(1, $clog2(NUM_WORDS))

Ports:
- clock  in  1  block clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  word write strobe, single cycle
- wr_addr  in  AW  word index; 0 = bits [WORD_WIDTH-1:0]
- wr_data  in  WORD_WIDTH  write data
- lock_set  in  1  pulse; sets the sticky write lock
- zeroize_req  in  1  pulse; starts a zeroization sequence
- key_out  out  KEY_WIDTH  key value; all zeros unless key_valid
- key_valid  out  1  all words written since the last reset or zeroize
- locked  out  1  write lock status
- wr_error  out  1  one-cycle pulse when a write is rejected
- zeroize_busy  out  1  zeroize sequence in progress
- zeroize_done  out  1  one-cycle pulse when a sequence completes
- zeroize_fail  out  1  sticky; set when verify finds a nonzero word
- par_error  out  1  sticky parity fault; see Configuration

## Operation
- **Storage.** NUM_WORDS x WORD_WIDTH registers, plus a NUM_WORDS written-mask.
- **Accepted write.** A write is accepted when wr_en=1, FSM is IDLE, locked=0, wr_addr<NUM_WORDS and zeroize_req=0. It updates the addressed word and sets its mask bit.
- **Rejected write.** Any other wr_en=1 cycle is a rejected write and pulses wr_error. Rejection causes: locked, busy, out-of-range address, or a simultaneous zeroize_req.
- **Rewrites.** Rewriting an already-written word is allowed while unlocked.
- **key_valid.** Equals AND of the written-mask.
- **key_out.** Equals the storage when key_valid=1, otherwise 0.
- **Lock.**
  - lock_set sets locked. Only reset clears it; zeroize does not.
  - Zeroize is always permitted, including while locked.
- **FSM states.** IDLE, WIPE1, WIPE0, VERIFY, DONE. A word counter cnt (AW bits) drives the wipe passes.
  - IDLE: zeroize_req=1 -> WIPE1 with cnt=0, and the written-mask clears immediately. A par_error rising edge (with the macro) also enters WIPE1.
  - WIPE1: word[cnt] <= all ones. When cnt==NUM_WORDS-1 -> WIPE0 with cnt=0, else cnt+1.
  - WIPE0: word[cnt] <= all zeros. When cnt==NUM_WORDS-1 -> VERIFY, else cnt+1.
  - VERIFY: any storage bit set -> set zeroize_fail. Then -> DONE.
  - DONE: zeroize_done=1 for one cycle -> IDLE.
- **zeroize_busy.** Equals 1 in WIPE1, WIPE0 and VERIFY.
- **zeroize_req when not IDLE.** Ignored; the request is not queued.
- **Reset.** Applies in any state, including mid-wipe. On reset:
  - all storage, written-mask, locked, cnt and status flags go to 0;
  - FSM goes to IDLE;
  - every output is 0.

## Timing
- Accepted write at edge N: key_out and key_valid reflect it after edge N (visible in cycle N+1).
- wr_error is registered: it pulses in the cycle after the rejected wr_en.
- zeroize_req sampled at edge N:
  - key_valid=0 and zeroize_busy=1 from cycle N+1;
  - busy lasts 2*NUM_WORDS+1 cycles;
  - zeroize_done pulses in the following cycle.
  - Default NUM_WORDS=8: busy for 17 cycles, done in cycle N+18.
- Simultaneous zeroize_req and wr_en in IDLE: zeroize wins, the write is dropped and wr_error pulses.
- Simultaneous lock_set and wr_en: the write is evaluated against the pre-edge lock, so it is accepted.

## Configuration
- **Macro SNVS_ZMK_PARITY_EN.**
- **Defined:**
  - each word carries an even-parity bit, written alongside the data and recomputed after each wipe write;
  - every cycle, all words with their mask bit set are checked;
  - a mismatch sets par_error (sticky until reset) and triggers an automatic zeroize from IDLE, with the same sequence as zeroize_req;
  - a mismatch while busy sets par_error only.
- **Undefined:** no parity storage or checker; par_error is tied to 0.

## Structure
- **Package snvs_lp_zmk_pkg** holds:
  - the FSM state enum zmk_state_t;
  - the default KEY_WIDTH and WORD_WIDTH;
  - a parity function, used only when SNVS_ZMK_PARITY_EN is defined.
- **Sub-module snvs_lp_zmk_word,** instantiated NUM_WORDS times in a generate loop:
  - one word register with write/wipe-ones/wipe-zeros mux;
  - synchronous reset;
  - optional parity bit and local mismatch output.
- **Top level** holds the FSM, counter, mask, lock, status flags and output gating.

## Test plan
- Reset, then write words 0..7 with 0x11111111*(i+1) -> key_valid=1 one cycle after the word-7 write; key_out[31:0]=0x11111111; key_out[255:224]=0x88888888.
- lock_set, then write addr 3 -> wr_error pulses; word 3 is unchanged; locked=1 persists across a zeroize.
- zeroize_req in IDLE -> busy for exactly 17 cycles; key_valid=0 from the next cycle; zeroize_done pulses once; storage is all zeros; zeroize_fail=0.
- Assert reset during WIPE1 at cnt=4 -> next cycle: all outputs 0, FSM IDLE; a new write is accepted normally.
- Simultaneous wr_en and zeroize_req; then zeroize_req and a write during busy -> first write dropped with wr_error; busy-period request ignored (a single done pulse); busy-period write raises wr_error.
- With SNVS_ZMK_PARITY_EN, force a bit flip in word 2 -> par_error=1 and an automatic zeroize runs; without the macro, par_error stays 0.
